// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame constants and the
// IO-page bit positions used when the receiver is mapped into the SoC.
package uart_pkg;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_START     = S_START,
      ST_DATA      = S_DATA,
      ST_STOP      = S_STOP,
      ST_WAIT_IDLE = S_WAIT_IDLE
   } rx_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   localparam int IO_UART_RX_DAT_bit     = 3;
   localparam int UART_CTRL_RX_VALID_bit = 8;

   function automatic logic [DATA_BITS-1:0] insert_bit(
      input logic [DATA_BITS-1:0] word,
      input logic [2:0]           idx,
      input logic                 bit_val
   );
      logic [DATA_BITS-1:0] res;
      res      = word;
      res[idx] = bit_val;
      return res;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver; a push that finds
// the FIFO full (and no simultaneous pop) is dropped and reported on o_drop.
module uart_rx_fifo
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             empty_s, full_s, pop_s, push_s;

   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A pop frees the slot first, so a push onto a full FIFO still lands.
   assign pop_s   = i_pop && !empty_s;
   assign push_s  = i_push && (!full_s || pop_s);

   // Pointer next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer and storage registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
         end
      end
   end

   assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];
   assign o_empty = empty_s;
   assign o_drop  = i_push && full_s && !pop_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, sticky error flags
// and a FWFT FIFO drained by the CPU through a valid/ready handshake.
module uart_rx
   import uart_pkg::*;
#(
   parameter int clk_freq_hz = 10_000_000,
   parameter int baud_rate   = 1_000_000,
   parameter int fifo_depth  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   input  logic       i_clr_err
);

   localparam int DIV   = clk_freq_hz / baud_rate;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV);

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(DIV - 1);
   localparam logic [2:0]       IDX_LAST      = 3'(DATA_BITS - 1);

   logic                 sync1_q, sync2_q, rx_s;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 push_q, push_d;
   logic [DATA_BITS-1:0] push_data_q, push_data_d;
   logic                 frame_evt_q, frame_evt_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 fifo_empty_s, drop_s;

   // Two-flop synchronizer, idle-high after reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= i_uart_rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

   // Receive FSM next-state
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      frame_evt_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF_LAST) begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  cnt_d   = {CNT_W{1'b0}};
                  idx_d   = 3'd0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_BIT_LAST) begin
               shreg_d = insert_bit(shreg_q, idx_q, rx_s);
               cnt_d   = {CNT_W{1'b0}};
               if (idx_q == IDX_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_BIT_LAST) begin
               cnt_d = {CNT_W{1'b0}};
               if (rx_s) begin
                  push_d      = 1'b1;
                  push_data_d = shreg_q;
                  state_d     = ST_IDLE;
               end else begin
                  frame_evt_d = 1'b1;
                  state_d     = ST_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_IDLE: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky flags: a set event in the same cycle as a clear wins
   always_comb begin
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      if (frame_evt_q) begin
         frame_err_d = 1'b1;
      end else if (i_clr_err) begin
         frame_err_d = 1'b0;
      end else begin
         frame_err_d = frame_err_q;
      end
      if (drop_s) begin
         overrun_d = 1'b1;
      end else if (i_clr_err) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // FSM, datapath and flag registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         idx_q       <= 3'd0;
         shreg_q     <= {DATA_BITS{1'b0}};
         push_q      <= 1'b0;
         push_data_q <= {DATA_BITS{1'b0}};
         frame_evt_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         frame_evt_q <= frame_evt_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (fifo_depth)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push_q),
      .i_wdata (push_data_q),
      .i_pop   (i_ready),
      .o_rdata (o_data),
      .o_empty (fifo_empty_s),
      .o_drop  (drop_s)
   );

   assign o_valid     = !fifo_empty_s;
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, timed corner cases
// and randomized frames against a queue-based reference model.
module tb_uart_rx;

   localparam int DIV   = 10;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_line;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       clr_err;

   int checks = 0;
   int errors = 0;

   logic       s97_v, s97_fe, s97_ov, s98_v, s98_fe, s98_ov;
   logic [7:0] s98_d;

   logic [7:0] model_q [$];
   logic       exp_fe, exp_ov;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_v98;
      logic       exp_fe98;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   uart_rx #(
      .clk_freq_hz (10_000_000),
      .baud_rate   (1_000_000),
      .fifo_depth  (DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_uart_rx   (rx_line),
      .o_data      (data),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_frame_err (frame_err),
      .o_overrun   (overrun),
      .i_clr_err   (clr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Line level at cycle c of a frame: start, 8 data bits LSB first, stop.
   function automatic logic line_bit(input logic [7:0] b, input logic stop, input int c);
      int slot;
      slot = c / DIV;
      if (slot == 0) return 1'b0;
      else if (slot <= 8) return b[slot-1];
      else return stop;
   endfunction

   // Drive frame cycles [lo,hi); the posedge after each assignment is edge c.
   task automatic drive_range(input logic [7:0] b, input logic stop, input int lo, input int hi);
      for (int c = lo; c < hi; c++) begin
         @(negedge clk);
         rx_line = line_bit(b, stop, c);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_range(b, stop, 0, 10 * DIV);
   endtask

   task automatic frame_timed(input logic [7:0] b, input logic stop, input logic rdy, input logic clr);
      drive_range(b, stop, 0, 98);
      @(posedge clk); #1;
      s97_v = valid; s97_fe = frame_err; s97_ov = overrun;
      @(negedge clk);
      rx_line = line_bit(b, stop, 98);
      ready   = rdy;
      clr_err = clr;
      @(posedge clk); #1;
      s98_v = valid; s98_fe = frame_err; s98_ov = overrun; s98_d = data;
      @(negedge clk);
      rx_line = line_bit(b, stop, 99);
      ready   = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      @(negedge clk);
      chk({name, "_valid"}, valid, 1'b1);
      chk({name, "_data"}, data, exp);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   task automatic release_break(input int low_cycles);
      repeat (low_cycles) @(negedge clk);
      rx_line = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic       bad;

      vecs[0] = '{data: 8'h55, stop: 1'b1, exp_v98: 1'b1, exp_fe98: 1'b0};
      vecs[1] = '{data: 8'h00, stop: 1'b1, exp_v98: 1'b1, exp_fe98: 1'b0};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_v98: 1'b1, exp_fe98: 1'b0};
      vecs[3] = '{data: 8'h80, stop: 1'b1, exp_v98: 1'b1, exp_fe98: 1'b0};
      vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_v98: 1'b0, exp_fe98: 1'b1};
      vecs[5] = '{data: 8'hA6, stop: 1'b1, exp_v98: 1'b1, exp_fe98: 1'b0};

      rst = 1'b1; rx_line = 1'b1; ready = 1'b0; clr_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         pulse_clear();
         frame_timed(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
         chk("tbl_valid97", s97_v, 1'b0);
         chk("tbl_ferr97", s97_fe, 1'b0);
         chk("tbl_valid98", s98_v, vecs[i].exp_v98);
         chk("tbl_ferr98", s98_fe, vecs[i].exp_fe98);
         chk("tbl_ovr98", s98_ov, 1'b0);
         if (vecs[i].exp_v98) begin
            chk("tbl_data98", s98_d, vecs[i].data);
            pop_expect("tbl_pop", vecs[i].data);
         end else begin
            release_break(20);
         end
         @(negedge clk);
         chk("tbl_empty", valid, 1'b0);
      end
      pulse_clear();

      // Short low glitch must be rejected without a flag.
      @(negedge clk);
      rx_line = 1'b0;
      repeat (3) @(negedge clk);
      rx_line = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_valid", valid, 1'b0);
      chk("glitch_ferr", frame_err, 1'b0);
      send_frame(8'h5A, 1'b1);
      pop_expect("glitch_after", 8'h5A);

      // Bad stop bit, break, then a good byte; flag stays until cleared.
      send_frame(8'h3C, 1'b0);
      release_break(20);
      send_frame(8'hA3, 1'b1);
      chk("fe_flag", frame_err, 1'b1);
      pop_expect("fe_next", 8'hA3);
      @(negedge clk);
      chk("fe_only_one", valid, 1'b0);
      pulse_clear();
      @(negedge clk);
      chk("fe_cleared", frame_err, 1'b0);

      frame_timed(8'h3C, 1'b0, 1'b0, 1'b1);
      chk("set_wins_ferr", s98_fe, 1'b1);
      release_break(5);
      pulse_clear();

      // Overrun: fifth byte dropped when nobody drains.
      for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1);
      frame_timed(8'h05, 1'b1, 1'b0, 1'b0);
      chk("ovr97", s97_ov, 1'b0);
      chk("ovr98", s98_ov, 1'b1);
      chk("ovr_head", s98_d, 8'h01);
      for (int k = 1; k <= 4; k++) pop_expect("ovr_drain", 8'(k));
      @(negedge clk);
      chk("ovr_empty", valid, 1'b0);
      pulse_clear();

      // Pop coinciding with push on a full FIFO.
      for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1);
      frame_timed(8'h05, 1'b1, 1'b1, 1'b0);
      chk("simul_ovr", s98_ov, 1'b0);
      chk("simul_head", s98_d, 8'h02);
      for (int k = 2; k <= 5; k++) pop_expect("simul_drain", 8'(k));
      @(negedge clk);
      chk("simul_empty", valid, 1'b0);

      // Reset in the middle of a frame with a byte still buffered.
      send_frame(8'h11, 1'b1);
      drive_range(8'h99, 1'b1, 0, 41);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", valid, 1'b0);
      chk("midrst_data", data, 8'h00);
      drive_range(8'h99, 1'b1, 41, 70);
      chk("midrst_valid2", valid, 1'b0);
      chk("midrst_ferr", frame_err, 1'b0);
      chk("midrst_ovr", overrun, 1'b0);
      drive_range(8'h99, 1'b1, 70, 100);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send_frame(8'h7E, 1'b1);
      chk("postrst_ferr", frame_err, 1'b0);
      chk("postrst_ovr", overrun, 1'b0);
      pop_expect("postrst", 8'h7E);
      @(negedge clk);
      chk("postrst_empty", valid, 1'b0);

      // Randomized frames against the queue model.
      model_q.delete();
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      for (int i = 0; i < 40; i++) begin
         b   = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_frame(b, !bad);
         if (bad) begin
            exp_fe = 1'b1;
            release_break($urandom_range(0, 15));
         end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
         end else begin
            exp_ov = 1'b1;
         end
         chk("rnd_ferr", frame_err, exp_fe);
         chk("rnd_ovr", overrun, exp_ov);
         chk("rnd_valid", valid, model_q.size() != 0);
         if (model_q.size() != 0) chk("rnd_head", data, model_q[0]);
         if ($urandom_range(0, 2) == 0) begin
            while (model_q.size() > 0) pop_expect("rnd_pop", model_q.pop_front());
         end
         if ($urandom_range(0, 4) == 0) begin
            pulse_clear();
            exp_fe = 1'b0;
            exp_ov = 1'b0;
         end
      end
      while (model_q.size() > 0) pop_expect("rnd_final", model_q.pop_front());
      @(negedge clk);
      chk("rnd_empty", valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
